// File: rtl/dot_product_feeder_if.sv
// Handshake and data bundle between the vector loader, the feeder and the dot-product engine.
interface dot_product_feeder_if #(
   parameter int unsigned LANES = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned LEN_W = $clog2(DEPTH + 1);
   localparam int unsigned BW    = LANES * DW;

   logic             start_valid;
   logic             start_ready;
   logic [LEN_W-1:0] start_len;
   logic             in_valid;
   logic             in_ready;
   logic [BW-1:0]    in_data;
   logic [BW-1:0]    in_wgt;
   logic             compute;
   logic [BW-1:0]    t_data;
   logic [BW-1:0]    weights;
   logic             out_valid;
   logic [ACC_W-1:0] dot_product;
   logic             res_valid;
   logic             res_ready;
   logic [ACC_W-1:0] res_data;
   logic             res_err;
   logic             busy;

   // Feeder side
   modport slave (
      input  start_valid, start_len, in_valid, in_data, in_wgt,
             out_valid, dot_product, res_ready,
      output start_ready, in_ready, compute, t_data, weights,
             res_valid, res_data, res_err, busy
   );

   // Environment side (loader, engine, result consumer)
   modport master (
      output start_valid, start_len, in_valid, in_data, in_wgt,
             out_valid, dot_product, res_ready,
      input  start_ready, in_ready, compute, t_data, weights,
             res_valid, res_data, res_err, busy
   );
endinterface

// File: rtl/dot_product_feeder.sv
// Buffers one vector of data/weight beats, replays it as a gap-free compute burst,
// then waits (bounded) for the engine result and returns it on a valid/ready port.
module dot_product_feeder #(
   parameter int unsigned LANES = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TMO   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dot_product_feeder_if.slave  bus
);
   localparam int unsigned LEN_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned TMO_W = $clog2(TMO + 1);
   localparam int unsigned BW    = LANES * DW;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] BURST = 3'd2;
   localparam logic [2:0] GAP   = 3'd3;
   localparam logic [2:0] WAIT  = 3'd4;
   localparam logic [2:0] HOLD  = 3'd5;

   logic [2:0]       state, state_nxt;
   logic [LEN_W-1:0] len_q, len_nxt;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
   logic [TMO_W-1:0] tmo_q, tmo_nxt;

   logic             start_ready_q, start_ready_nxt;
   logic             in_ready_q, in_ready_nxt;
   logic             compute_q, compute_nxt;
   logic [BW-1:0]    t_data_q, t_data_nxt;
   logic [BW-1:0]    weights_q, weights_nxt;
   logic             res_valid_q, res_valid_nxt;
   logic [ACC_W-1:0] res_data_q, res_data_nxt;
   logic             res_err_q, res_err_nxt;
   logic             busy_q, busy_nxt;
   logic             wr_en_c;

   logic [BW-1:0]    data_mem [DEPTH];
   logic [BW-1:0]    wgt_mem  [DEPTH];

   // Beat buffer; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         data_mem[wr_ptr] <= bus.in_data;
         wgt_mem[wr_ptr]  <= bus.in_wgt;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         len_q         <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         tmo_q         <= '0;
         start_ready_q <= 1'b1;
         in_ready_q    <= 1'b0;
         compute_q     <= 1'b0;
         t_data_q      <= '0;
         weights_q     <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_err_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state         <= state_nxt;
         len_q         <= len_nxt;
         wr_ptr        <= wr_ptr_nxt;
         rd_ptr        <= rd_ptr_nxt;
         tmo_q         <= tmo_nxt;
         start_ready_q <= start_ready_nxt;
         in_ready_q    <= in_ready_nxt;
         compute_q     <= compute_nxt;
         t_data_q      <= t_data_nxt;
         weights_q     <= weights_nxt;
         res_valid_q   <= res_valid_nxt;
         res_data_q    <= res_data_nxt;
         res_err_q     <= res_err_nxt;
         busy_q        <= busy_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt       = state;
      len_nxt         = len_q;
      wr_ptr_nxt      = wr_ptr;
      rd_ptr_nxt      = rd_ptr;
      tmo_nxt         = tmo_q;
      start_ready_nxt = start_ready_q;
      in_ready_nxt    = in_ready_q;
      compute_nxt     = compute_q;
      t_data_nxt      = t_data_q;
      weights_nxt     = weights_q;
      res_valid_nxt   = res_valid_q;
      res_data_nxt    = res_data_q;
      res_err_nxt     = res_err_q;
      wr_en_c         = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start_valid && start_ready_q) begin
               len_nxt         = bus.start_len;
               start_ready_nxt = 1'b0;
               if ((bus.start_len == '0) || (bus.start_len > LEN_W'(DEPTH))) begin
                  // Unserviceable length: report error without touching the engine
                  state_nxt     = HOLD;
                  res_valid_nxt = 1'b1;
                  res_err_nxt   = 1'b1;
                  res_data_nxt  = '0;
               end else begin
                  state_nxt    = LOAD;
                  wr_ptr_nxt   = '0;
                  in_ready_nxt = 1'b1;
               end
            end
         end

         LOAD: begin
            if (bus.in_valid && in_ready_q) begin
               wr_en_c    = 1'b1;
               wr_ptr_nxt = wr_ptr + PTR_W'(1);
               if (LEN_W'(wr_ptr) == (len_q - LEN_W'(1))) begin
                  state_nxt    = BURST;
                  in_ready_nxt = 1'b0;
                  compute_nxt  = 1'b1;
                  rd_ptr_nxt   = '0;
                  // A one-beat vector is still in flight to the buffer, so bypass it
                  if (wr_ptr == '0) begin
                     t_data_nxt  = bus.in_data;
                     weights_nxt = bus.in_wgt;
                  end else begin
                     t_data_nxt  = data_mem[0];
                     weights_nxt = wgt_mem[0];
                  end
               end
            end
         end

         BURST: begin
            if (LEN_W'(rd_ptr) == (len_q - LEN_W'(1))) begin
               state_nxt   = GAP;
               compute_nxt = 1'b0;
               t_data_nxt  = '0;
               weights_nxt = '0;
            end else begin
               rd_ptr_nxt  = rd_ptr + PTR_W'(1);
               t_data_nxt  = data_mem[rd_ptr + PTR_W'(1)];
               weights_nxt = wgt_mem[rd_ptr + PTR_W'(1)];
            end
         end

         GAP: begin
            state_nxt = WAIT;
            tmo_nxt   = '0;
         end

         WAIT: begin
            if (bus.out_valid) begin
               state_nxt     = HOLD;
               res_valid_nxt = 1'b1;
               res_err_nxt   = 1'b0;
               res_data_nxt  = bus.dot_product;
            end else if (tmo_q == TMO_W'(TMO - 1)) begin
               state_nxt     = HOLD;
               res_valid_nxt = 1'b1;
               res_err_nxt   = 1'b1;
               res_data_nxt  = '0;
            end else begin
               tmo_nxt = tmo_q + TMO_W'(1);
            end
         end

         HOLD: begin
            if (bus.res_ready && res_valid_q) begin
               state_nxt       = IDLE;
               res_valid_nxt   = 1'b0;
               res_err_nxt     = 1'b0;
               start_ready_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt       = IDLE;
            start_ready_nxt = 1'b1;
            in_ready_nxt    = 1'b0;
            compute_nxt     = 1'b0;
            t_data_nxt      = '0;
            weights_nxt     = '0;
            res_valid_nxt   = 1'b0;
            res_err_nxt     = 1'b0;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   assign bus.start_ready = start_ready_q;
   assign bus.in_ready    = in_ready_q;
   assign bus.compute     = compute_q;
   assign bus.t_data      = t_data_q;
   assign bus.weights     = weights_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;
   assign bus.res_err     = res_err_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_dot_product_feeder.sv
// Bench for dot_product_feeder: job table with beat/result scoreboards and an engine model.
module tb_dot_product_feeder;
   localparam int unsigned LANES = 8;
   localparam int unsigned DW    = 8;
   localparam int unsigned ACC_W = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TMO   = 16;
   localparam int unsigned LEN_W = $clog2(DEPTH + 1);
   localparam int unsigned BW    = LANES * DW;
   localparam logic [ACC_W-1:0] JUNK = 32'hDEADBEEF;

   typedef struct {
      int               len;
      bit               gappy;
      int               dly;      // negedges after GAP to pulse out_valid; -1 = never
      logic [ACC_W-1:0] result;
      int               hold;     // cycles res_ready stays low once res_valid is seen
      bit               stray;    // stray out_valid during burst
      int               rst_at;   // >0: reset on this compute cycle
      logic             exp_err;
      logic [ACC_W-1:0] exp_data;
   } vec_t;

   typedef struct {
      logic [BW-1:0] data;
      logic [BW-1:0] wgt;
   } beat_t;

   typedef struct {
      logic             err;
      logic [ACC_W-1:0] data;
   } res_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   beat_t exp_beats[$];
   res_t  res_q[$];

   dot_product_feeder_if #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .DEPTH(DEPTH)) bus ();

   dot_product_feeder #(
      .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .DEPTH(DEPTH), .TMO(TMO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Beat scoreboard: every compute-high cycle must present the next loaded beat
   always @(negedge clk) begin
      beat_t b;
      if (rst_n) begin
         if (bus.compute) begin
            if (exp_beats.size() == 0) begin
               check("compute_unexpected", 64'(bus.compute), 64'd0);
            end else begin
               b = exp_beats.pop_front();
               check("t_data", bus.t_data, b.data);
               check("weights", bus.weights, b.wgt);
            end
         end else begin
            check("t_data_idle", bus.t_data, 64'd0);
            check("weights_idle", bus.weights, 64'd0);
         end
      end
   end

   task automatic run_job(input vec_t v);
      int    cyc;
      int    i;
      int    n;
      bit    hs;
      beat_t b;
      res_t  r;

      cyc = 0;
      while (!bus.start_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("start_ready_before_job", 64'(bus.start_ready), 64'd1);
      bus.start_valid = 1'b1;
      bus.start_len   = LEN_W'(v.len);
      @(negedge clk);
      bus.start_valid = 1'b0;
      check("busy_after_start", 64'(bus.busy), 64'd1);
      check("start_ready_low", 64'(bus.start_ready), 64'd0);

      if (v.len == 0 || v.len > int'(DEPTH)) begin
         res_q.push_back('{err: v.exp_err, data: v.exp_data});
         check("bad_len_res_valid", 64'(bus.res_valid), 64'd1);
         check("bad_len_in_ready", 64'(bus.in_ready), 64'd0);
      end else begin
         i   = 0;
         cyc = 0;
         b.data = {$urandom(), $urandom()};
         b.wgt  = {$urandom(), $urandom()};
         while (i < v.len && cyc < 200) begin
            bus.in_valid = v.gappy ? ((cyc % 2) == 0) : 1'b1;
            bus.in_data  = b.data;
            bus.in_wgt   = b.wgt;
            hs = bus.in_valid && bus.in_ready;
            if (hs) begin
               exp_beats.push_back(b);
               i++;
               b.data = {$urandom(), $urandom()};
               b.wgt  = {$urandom(), $urandom()};
            end
            @(negedge clk);
            cyc++;
         end
         bus.in_valid = 1'b0;
         check("load_complete", 64'(i), 64'(v.len));
         check("first_compute_latency", 64'(bus.compute), 64'd1);
         check("in_ready_after_load", 64'(bus.in_ready), 64'd0);

         n   = 1;
         cyc = 0;
         while (cyc < 100) begin
            if (v.rst_at > 0 && n == v.rst_at) begin
               rst_n = 1'b0;
               #1;
               check("rst_compute", 64'(bus.compute), 64'd0);
               check("rst_busy", 64'(bus.busy), 64'd0);
               check("rst_start_ready", 64'(bus.start_ready), 64'd1);
               check("rst_t_data", bus.t_data, 64'd0);
               exp_beats.delete();
               @(negedge clk);
               rst_n = 1'b1;
               @(negedge clk);
               return;
            end
            if (v.stray && n == 2) begin
               bus.out_valid   = 1'b1;
               bus.dot_product = 32'hBAD0BAD0;
            end else begin
               bus.out_valid   = 1'b0;
               bus.dot_product = JUNK;
            end
            @(negedge clk);
            cyc++;
            if (!bus.compute) break;
            n++;
         end
         bus.out_valid   = 1'b0;
         bus.dot_product = JUNK;
         check("burst_len", 64'(n), 64'(v.len));
         check("beats_drained", 64'(exp_beats.size()), 64'd0);
         res_q.push_back('{err: v.exp_err, data: v.exp_data});

         if (v.dly >= 0) begin
            for (int k = 0; k < v.dly; k++) @(negedge clk);
            check("res_valid_before_engine", 64'(bus.res_valid), 64'd0);
            bus.out_valid   = 1'b1;
            bus.dot_product = v.result;
            @(negedge clk);
            bus.out_valid   = 1'b0;
            bus.dot_product = JUNK;
            check("res_latency", 64'(bus.res_valid), 64'd1);
         end else begin
            for (int k = 0; k < int'(TMO); k++) @(negedge clk);
            check("tmo_not_early", 64'(bus.res_valid), 64'd0);
            @(negedge clk);
            check("tmo_flagged", 64'(bus.res_valid), 64'd1);
         end
      end

      cyc = 0;
      while (!bus.res_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("res_valid_seen", 64'(bus.res_valid), 64'd1);
      r = '{err: 1'b0, data: '0};
      if (res_q.size() > 0) r = res_q.pop_front();
      for (int h = 0; h < v.hold; h++) begin
         check("hold_res_valid", 64'(bus.res_valid), 64'd1);
         check("hold_res_data", 64'(bus.res_data), 64'(r.data));
         check("hold_start_ready", 64'(bus.start_ready), 64'd0);
         check("hold_busy", 64'(bus.busy), 64'd1);
         @(negedge clk);
      end
      check("res_data", 64'(bus.res_data), 64'(r.data));
      check("res_err", 64'(bus.res_err), 64'(r.err));
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check("res_valid_cleared", 64'(bus.res_valid), 64'd0);
      check("start_ready_back", 64'(bus.start_ready), 64'd1);
      check("busy_cleared", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
      $fatal(1);
   end

   initial begin
      vec_t tbl[11];
      tbl[0]  = '{len:3,  gappy:0, dly:1,  result:32'h0000002A, hold:0, stray:0, rst_at:0, exp_err:0, exp_data:32'h0000002A};
      tbl[1]  = '{len:16, gappy:1, dly:3,  result:32'h12345678, hold:0, stray:0, rst_at:0, exp_err:0, exp_data:32'h12345678};
      tbl[2]  = '{len:0,  gappy:0, dly:1,  result:32'h11111111, hold:0, stray:0, rst_at:0, exp_err:1, exp_data:32'h0};
      tbl[3]  = '{len:17, gappy:0, dly:1,  result:32'h22222222, hold:0, stray:0, rst_at:0, exp_err:1, exp_data:32'h0};
      tbl[4]  = '{len:5,  gappy:0, dly:-1, result:32'h33333333, hold:0, stray:1, rst_at:0, exp_err:1, exp_data:32'h0};
      tbl[5]  = '{len:4,  gappy:0, dly:2,  result:32'hCAFEF00D, hold:5, stray:0, rst_at:0, exp_err:0, exp_data:32'hCAFEF00D};
      tbl[6]  = '{len:8,  gappy:0, dly:1,  result:32'h44444444, hold:0, stray:0, rst_at:3, exp_err:0, exp_data:32'h44444444};
      tbl[7]  = '{len:3,  gappy:1, dly:1,  result:32'h000000A5, hold:0, stray:0, rst_at:0, exp_err:0, exp_data:32'h000000A5};
      tbl[8]  = '{len:1,  gappy:0, dly:1,  result:32'hFFFFFFFF, hold:0, stray:0, rst_at:0, exp_err:0, exp_data:32'hFFFFFFFF};
      tbl[9]  = '{len:2,  gappy:1, dly:16, result:32'h80000001, hold:0, stray:0, rst_at:0, exp_err:0, exp_data:32'h80000001};
      tbl[10] = '{len:16, gappy:0, dly:1,  result:32'h00000007, hold:2, stray:0, rst_at:0, exp_err:0, exp_data:32'h00000007};

      n_checks        = 0;
      n_fail          = 0;
      rst_n           = 1'b0;
      bus.start_valid = 1'b0;
      bus.start_len   = '0;
      bus.in_valid    = 1'b0;
      bus.in_data     = '0;
      bus.in_wgt      = '0;
      bus.out_valid   = 1'b0;
      bus.dot_product = JUNK;
      bus.res_ready   = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_start_ready", 64'(bus.start_ready), 64'd1);
      check("reset_in_ready", 64'(bus.in_ready), 64'd0);
      check("reset_compute", 64'(bus.compute), 64'd0);
      check("reset_res_valid", 64'(bus.res_valid), 64'd0);
      check("reset_res_err", 64'(bus.res_err), 64'd0);
      check("reset_res_data", 64'(bus.res_data), 64'd0);
      check("reset_busy", 64'(bus.busy), 64'd0);
      check("reset_t_data", bus.t_data, 64'd0);
      check("reset_weights", bus.weights, 64'd0);

      // Stale engine strobe while idle must not produce a result
      bus.out_valid = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      bus.out_valid = 1'b0;
      @(negedge clk);
      check("idle_out_valid_ignored", 64'(bus.res_valid), 64'd0);

      for (int t = 0; t < 11; t++) run_job(tbl[t]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
